// File: rtl/friscv_h.sv
// Shared constants for the friscv machine-level interrupt controller:
// MIP/MIE bit positions, interrupt exception codes and FSM states.
package friscv_h;

  localparam int unsigned MSI_BIT = 3;
  localparam int unsigned MTI_BIT = 7;
  localparam int unsigned MEI_BIT = 11;

  localparam logic [3:0] MSI_CODE = 4'd3;
  localparam logic [3:0] MTI_CODE = 4'd7;
  localparam logic [3:0] MEI_CODE = 4'd11;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_BUSY = 2'd2
  } irq_state_t;

endpackage

// File: rtl/friscv_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level into aclk.
module friscv_bit_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic srst,
  input  logic bit_i,
  output logic bit_o
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], bit_i};
    if (srst) sync_d = '0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign bit_o = sync_q[DEPTH-1];

endmodule

// File: rtl/friscv_irq_ctrl.sv
// Machine interrupt controller: registers CLINT/external levels into MIP,
// masks and prioritises them, and issues one trap request per mret.
module friscv_irq_ctrl
  import friscv_h::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            sw_irq,
  input  logic            timer_irq,
  input  logic            ext_irq,
  input  logic            mie_global,
  input  logic [XLEN-1:0] mie,
  output logic            irq_valid,
  output logic [XLEN-1:0] irq_cause,
  input  logic            irq_ready,
  input  logic            irq_done,
  output logic [XLEN-1:0] mip
);

  logic            areset_n;
  logic            ext_sync;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] elig;
  logic [3:0]      win_code;
  logic [XLEN-1:0] win_cause;
  irq_state_t      state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] cause_q, cause_d;

  assign areset_n = ~areset;

  friscv_bit_sync #(
    .DEPTH (2)
  ) u_ext_sync (
    .aclk    (aclk),
    .aresetn (areset_n),
    .srst    (1'b0),
    .bit_i   (ext_irq),
    .bit_o   (ext_sync)
  );

  // Level mirror of the three live sources; every other MIP bit reads 0.
  always_comb begin
    mip_d          = '0;
    mip_d[MSI_BIT] = sw_irq;
    mip_d[MTI_BIT] = timer_irq;
    mip_d[MEI_BIT] = ext_sync;
  end

  // Only bits 3/7/11 of mip_q can be set, so masking with the full MIE is safe.
  assign elig = mip_q & mie;

  always_comb begin
    if (elig[MEI_BIT])      win_code = MEI_CODE;
    else if (elig[MSI_BIT]) win_code = MSI_CODE;
    else                    win_code = MTI_CODE;
    win_cause = {1'b1, {(XLEN-5){1'b0}}, win_code};
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    cause_d = cause_q;
    case (state_q)
      IRQ_IDLE: begin
        valid_d = 1'b0;
        if (mie_global && (|elig)) begin
          state_d = IRQ_REQ;
          valid_d = 1'b1;
          cause_d = win_cause;
        end
      end
      IRQ_REQ: begin
        if (irq_ready) begin
          state_d = IRQ_BUSY;
          valid_d = 1'b0;
        end
      end
      IRQ_BUSY: begin
        valid_d = 1'b0;
        if (irq_done) state_d = IRQ_IDLE;
      end
      default: begin
        state_d = IRQ_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mip_q   <= '0;
      state_q <= IRQ_IDLE;
      valid_q <= 1'b0;
      cause_q <= '0;
    end else begin
      mip_q   <= mip_d;
      state_q <= state_d;
      valid_q <= valid_d;
      cause_q <= cause_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_cause = cause_q;
  assign mip       = mip_q;

endmodule
